// File: rtl/turkey_gun_pkg.sv
// +-----------------------------------------------------------------+
// | turkey_gun_pkg : shared types/constants for the gun controller  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package turkey_gun_pkg;

  typedef enum logic [1:0] {
    AX_IDLE = 2'd0,
    AX_SLOW = 2'd1,
    AX_FAST = 2'd2
  } axis_state_t;

  localparam int GUN_W_DEF  = 6;
  localparam int GUN_MAX    = (1 << GUN_W_DEF) - 1;
  localparam int CENTER_DEF = 32;

endpackage

`default_nettype wire

// File: rtl/gun_axis.sv
// +-----------------------------------------------------------------+
// | gun_axis : one crosshair axis, paced FSM + saturating position  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module gun_axis
  import turkey_gun_pkg::*;
#(
  parameter int GUN_W       = GUN_W_DEF,
  parameter int DIV_SLOW    = 3,
  parameter int ACCEL_TICKS = 32,
  parameter int CENTER      = CENTER_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clear,
  input  logic             absolute,
  input  logic [GUN_W-1:0] load_val,
  input  logic             dec,
  input  logic             inc,
  output logic [GUN_W-1:0] pos,
  output logic             active
);

  localparam int DIV_W  = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [GUN_W-1:0]  C_POS_MAX = '1;
  localparam logic [GUN_W-1:0]  C_CENTER  = GUN_W'(CENTER);
  localparam logic [DIV_W-1:0]  C_DIV_TOP = DIV_W'(DIV_SLOW - 1);
  localparam logic [HOLD_W-1:0] C_ACCEL   = HOLD_W'(ACCEL_TICKS);

  axis_state_t       r_state;
  logic [DIV_W-1:0]  r_div;
  logic [HOLD_W-1:0] r_hold;
  logic              r_dir;

  logic              w_valid;
  logic              w_div_wrap;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [GUN_W-1:0]  w_step_pos;

  assign w_valid    = dec ^ inc;
  assign w_div_wrap = (r_div == C_DIV_TOP);
  assign w_div_nxt  = w_div_wrap ? '0 : r_div + 1'b1;
  assign w_hold_nxt = (r_hold == C_ACCEL) ? r_hold : r_hold + 1'b1;

  // Pinned at either rail the position simply holds; no wrap-around.
  always_comb begin
    w_step_pos = pos;
    if (inc && pos != C_POS_MAX) begin
      w_step_pos = pos + 1'b1;
    end else if (!inc && pos != '0) begin
      w_step_pos = pos - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= AX_IDLE;
      r_div   <= '0;
      r_hold  <= '0;
      r_dir   <= 1'b0;
      pos     <= C_CENTER;
      active  <= 1'b0;
    end else if (clear) begin
      r_state <= AX_IDLE;
      r_div   <= '0;
      r_hold  <= '0;
      r_dir   <= 1'b0;
      pos     <= C_CENTER;
      active  <= 1'b0;
    end else if (absolute) begin
      r_state <= AX_IDLE;
      r_div   <= '0;
      r_hold  <= '0;
      active  <= 1'b0;
      if (tick) begin
        pos <= load_val;
      end
    end else if (tick) begin
      case (r_state)
        AX_IDLE: begin
          if (w_valid) begin
            r_state <= AX_SLOW;
            r_div   <= '0;
            r_hold  <= '0;
            r_dir   <= inc;
            pos     <= w_step_pos;
            active  <= 1'b1;
          end
        end
        default: begin
          if (!w_valid) begin
            r_state <= AX_IDLE;
            r_div   <= '0;
            r_hold  <= '0;
            active  <= 1'b0;
          end else if (inc != r_dir) begin
            // Reversal restarts the slow phase with an immediate step.
            r_state <= AX_SLOW;
            r_div   <= '0;
            r_hold  <= '0;
            r_dir   <= inc;
            pos     <= w_step_pos;
          end else if (r_state == AX_SLOW) begin
            r_div  <= w_div_nxt;
            r_hold <= w_hold_nxt;
            if (w_div_wrap) begin
              pos <= w_step_pos;
            end
            if (w_hold_nxt == C_ACCEL) begin
              r_state <= AX_FAST;
            end
          end else begin
            pos <= w_step_pos;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/turkey_gun_ctrl.sv
// +-----------------------------------------------------------------+
// | turkey_gun_ctrl : joystick/analog to gun_h/gun_v crosshair      |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module turkey_gun_ctrl
  import turkey_gun_pkg::*;
#(
  parameter int GUN_W       = GUN_W_DEF,
  parameter int DIV_SLOW    = 3,
  parameter int ACCEL_TICKS = 32,
  parameter int CENTER      = CENTER_DEF
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             tick_4ms,
  input  logic             joy_left,
  input  logic             joy_right,
  input  logic             joy_up,
  input  logic             joy_down,
  input  logic             center_req,
  input  logic             analog_en,
  input  logic [7:0]       analog_x,
  input  logic [7:0]       analog_y,
  output logic [GUN_W-1:0] gun_h,
  output logic [GUN_W-1:0] gun_v,
  output logic             gun_moving
);

  logic r_tick_q;
  logic w_tick;
  logic w_h_active;
  logic w_v_active;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_q <= 1'b0;
    end else begin
      r_tick_q <= tick_4ms;
    end
  end

  assign w_tick = tick_4ms & ~r_tick_q;

  generate
    if (GUN_W < 8) begin : g_unused_lsbs
      logic unused_analog_lsbs;
      assign unused_analog_lsbs = ^{analog_x[7-GUN_W:0], analog_y[7-GUN_W:0]};
    end
  endgenerate

  gun_axis #(
    .GUN_W       (GUN_W),
    .DIV_SLOW    (DIV_SLOW),
    .ACCEL_TICKS (ACCEL_TICKS),
    .CENTER      (CENTER)
  ) u_axis_h (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .tick     (w_tick),
    .clear    (center_req),
    .absolute (analog_en),
    .load_val (analog_x[7 -: GUN_W]),
    .dec      (joy_left),
    .inc      (joy_right),
    .pos      (gun_h),
    .active   (w_h_active)
  );

  gun_axis #(
    .GUN_W       (GUN_W),
    .DIV_SLOW    (DIV_SLOW),
    .ACCEL_TICKS (ACCEL_TICKS),
    .CENTER      (CENTER)
  ) u_axis_v (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .tick     (w_tick),
    .clear    (center_req),
    .absolute (analog_en),
    .load_val (analog_y[7 -: GUN_W]),
    .dec      (joy_up),
    .inc      (joy_down),
    .pos      (gun_v),
    .active   (w_v_active)
  );

  // Both inputs are flop outputs, so this stays glitch-free.
  assign gun_moving = w_h_active | w_v_active;

endmodule

`default_nettype wire

// File: tb/tb_turkey_gun_ctrl.sv
// +-----------------------------------------------------------------+
// | tb_turkey_gun_ctrl : directed + random bench with ref model     |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_turkey_gun_ctrl;

  localparam int GW   = 6;
  localparam int DIV  = 3;
  localparam int ACC  = 32;
  localparam int CTR  = 32;
  localparam int PMAX = (1 << GW) - 1;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          tick_4ms;
  logic          joy_left, joy_right, joy_up, joy_down;
  logic          center_req, analog_en;
  logic [7:0]    analog_x, analog_y;
  logic [GW-1:0] gun_h, gun_v;
  logic          gun_moving;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle / 1 slow / 2 fast, n = ticks since slow start.
  int m_tq;
  int m_h, m_v;
  int m_hmode, m_vmode, m_hn, m_vn, m_hdir, m_vdir;
  int m_moving;

  always #5 clk_sys = ~clk_sys;

  turkey_gun_ctrl #(
    .GUN_W(GW), .DIV_SLOW(DIV), .ACCEL_TICKS(ACC), .CENTER(CTR)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .tick_4ms   (tick_4ms),
    .joy_left   (joy_left),
    .joy_right  (joy_right),
    .joy_up     (joy_up),
    .joy_down   (joy_down),
    .center_req (center_req),
    .analog_en  (analog_en),
    .analog_x   (analog_x),
    .analog_y   (analog_y),
    .gun_h      (gun_h),
    .gun_v      (gun_v),
    .gun_moving (gun_moving)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int x);
    if (x < 0) return 0;
    if (x > PMAX) return PMAX;
    return x;
  endfunction

  task automatic model_reset();
    m_tq = 0; m_h = CTR; m_v = CTR;
    m_hmode = 0; m_vmode = 0; m_hn = 0; m_vn = 0; m_hdir = 0; m_vdir = 0;
    m_moving = 0;
  endtask

  task automatic axis_tick(input logic dec, input logic inc, inout int pos,
                           inout int mode, inout int n, inout int dir);
    int d;
    if (dec == inc) begin
      mode = 0;
      n    = 0;
    end else begin
      d = inc ? 1 : -1;
      if (mode == 0 || d != dir) begin
        mode = 1; n = 0; dir = d;
        pos = clamp(pos + d);
      end else if (mode == 1) begin
        n++;
        if (n % DIV == 0) pos = clamp(pos + d);
        if (n >= ACC) mode = 2;
      end else begin
        pos = clamp(pos + d);
      end
    end
  endtask

  task automatic model_edge();
    bit tk;
    tk   = tick_4ms && (m_tq == 0);
    m_tq = tick_4ms ? 1 : 0;
    if (center_req) begin
      m_h = CTR; m_v = CTR;
      m_hmode = 0; m_vmode = 0; m_hn = 0; m_vn = 0; m_hdir = 0; m_vdir = 0;
    end else if (analog_en) begin
      m_hmode = 0; m_vmode = 0; m_hn = 0; m_vn = 0;
      if (tk) begin
        m_h = int'(analog_x) >> (8 - GW);
        m_v = int'(analog_y) >> (8 - GW);
      end
    end else if (tk) begin
      axis_tick(joy_left, joy_right, m_h, m_hmode, m_hn, m_hdir);
      axis_tick(joy_up,   joy_down,  m_v, m_vmode, m_vn, m_vdir);
    end
    m_moving = (m_hmode != 0 || m_vmode != 0) ? 1 : 0;
  endtask

  task automatic step_clk();
    model_edge();
    @(posedge clk_sys);
    #1;
    chk("gun_h", int'(gun_h), m_h);
    chk("gun_v", int'(gun_v), m_v);
    chk("gun_moving", int'(gun_moving), m_moving);
  endtask

  task automatic do_ticks(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      tick_4ms = 1'b1;
      repeat (hi) step_clk();
      tick_4ms = 1'b0;
      repeat (lo) step_clk();
    end
  endtask

  task automatic set_joy(input logic l, input logic r, input logic u, input logic d);
    joy_left = l; joy_right = r; joy_up = u; joy_down = d;
  endtask

  task automatic recenter();
    center_req = 1'b1;
    step_clk();
    center_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; tick_4ms = 1'b0; center_req = 1'b0; analog_en = 1'b0;
    analog_x = 8'h00; analog_y = 8'h00;
    set_joy(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    chk("reset_h", int'(gun_h), CTR);
    chk("reset_v", int'(gun_v), CTR);
    chk("reset_moving", int'(gun_moving), 0);
    reset_n = 1'b1;
    step_clk();

    // Idle ticks leave the crosshair centred.
    do_ticks(10, 2, 2);
    chk("idle_h", int'(gun_h), 32);
    chk("idle_v", int'(gun_v), 32);

    // Slow start: steps on ticks 1 and 4.
    set_joy(0, 1, 0, 0);
    tick_4ms = 1'b1;
    step_clk();
    chk("first_press_moving", int'(gun_moving), 1);
    chk("first_press_h", int'(gun_h), 33);
    tick_4ms = 1'b0;
    step_clk();
    do_ticks(5, 2, 2);
    chk("slow6_h", int'(gun_h), 34);
    chk("slow6_v", int'(gun_v), 32);
    set_joy(0, 0, 0, 0);
    do_ticks(1, 2, 2);
    chk("release_moving", int'(gun_moving), 0);
    recenter();

    // Acceleration then saturation at 0.
    set_joy(1, 0, 0, 0);
    do_ticks(33, 1, 2);
    chk("accel_entry_h", int'(gun_h), 21);
    do_ticks(7, 1, 2);
    chk("fast40_h", int'(gun_h), 14);
    do_ticks(20, 1, 2);
    chk("floor_h", int'(gun_h), 0);
    chk("floor_moving", int'(gun_moving), 1);
    set_joy(0, 0, 0, 0);
    do_ticks(1, 1, 2);
    chk("floor_release_moving", int'(gun_moving), 0);
    recenter();

    // Both horizontal buttons is invalid; vertical runs independently.
    set_joy(1, 1, 1, 0);
    do_ticks(5, 2, 1);
    chk("both_h", int'(gun_h), 32);
    chk("up_v", int'(gun_v), 30);
    set_joy(0, 0, 0, 0);
    recenter();

    // Analog absolute mode, then recentre without a tick.
    analog_en = 1'b1; analog_x = 8'hFF; analog_y = 8'h00;
    do_ticks(1, 1, 1);
    chk("analog_h", int'(gun_h), 63);
    chk("analog_v", int'(gun_v), 0);
    analog_en = 1'b0;
    recenter();
    chk("center_h", int'(gun_h), 32);
    chk("center_v", int'(gun_v), 32);

    // Async reset during FAST.
    set_joy(0, 1, 0, 0);
    do_ticks(40, 1, 2);
    chk("fast_h50", int'(gun_h), 50);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_h", int'(gun_h), CTR);
    chk("async_rst_moving", int'(gun_moving), 0);
    model_reset();
    @(posedge clk_sys);
    #2;
    reset_n = 1'b1;
    tick_4ms = 1'b1;
    step_clk();
    chk("post_rst_h", int'(gun_h), 33);
    tick_4ms = 1'b0;
    step_clk();

    // Randomized segments against the reference model.
    for (int s = 0; s < 300; s++) begin
      int nt;
      set_joy(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      center_req = ($urandom_range(0, 15) == 0);
      analog_en  = ($urandom_range(0, 7) == 0);
      analog_x   = 8'($urandom);
      analog_y   = 8'($urandom);
      nt = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 8);
      do_ticks(nt, $urandom_range(1, 3), $urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
